mic_capture_ctrl: RTL

- Sequencer for the microphone SPI reader.
- Issues one conversion request per sample period and waits for the reader's data strobe, with a timeout.
- Tracks the DC baseline of the signal, measures per-sample amplitude and peak-holds it over a window of samples.
- Reports the window level plus a hysteretic "loud" flag, which the game logic uses as the jump trigger.

---
 rtl/mic_capture_if.sv | 33 +++
 rtl/mic_capture_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mic_capture_if.sv
// Sequencer <-> reader/game-logic signal bundle for mic_capture_ctrl.
//   enable      : run sampling when high (from game logic)
//   rdStart     : one-cycle conversion request to the SPI reader
//   rdData      : reader sample, bit 15 ignored
//   rdStrobe    : reader data-valid, rdData valid while high
//   level       : peak amplitude of the last completed window
//   levelStrobe : one-cycle pulse when level/loud update
//   loud        : hysteretic loudness flag
//   timeoutErr  : sticky, a conversion timed out
//   overrunErr  : sticky, a tick arrived while a conversion was in flight
interface mic_capture_if;
    logic        enable;
    logic        rdStart;
    logic [15:0] rdData;
    logic        rdStrobe;
    logic [14:0] level;
    logic        levelStrobe;
    logic        loud;
    logic        timeoutErr;
    logic        overrunErr;

    // Controller side.
    modport master (
        input  enable, rdData, rdStrobe,
        output rdStart, level, levelStrobe, loud, timeoutErr, overrunErr
    );

    // Reader / game-logic side.
    modport slave (
        output enable, rdData, rdStrobe,
        input  rdStart, level, levelStrobe, loud, timeoutErr, overrunErr
    );
endinterface

// File: rtl/mic_capture_ctrl.sv
// Microphone capture sequencer: requests one conversion per sample period,
// tracks the DC baseline, peak-holds amplitude over a window of samples and
// reports the window level plus a hysteretic loud flag.
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : mic_capture_if.master (see interface for signal list)
module mic_capture_ctrl #(
    parameter int unsigned PERIOD      = 3125,
    parameter int unsigned TIMEOUT     = 2048,
    parameter int unsigned WINDOW_LOG2 = 5,
    parameter int unsigned BASE_SHIFT  = 6,
    parameter logic [14:0] THRESH_ON   = 15'h0400,
    parameter logic [14:0] THRESH_OFF  = 15'h0200
) (
    input  logic          clk,
    input  logic          rst,
    mic_capture_if.master bus
);
    localparam int unsigned CNT_W = $clog2(PERIOD);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned WIN_W = WINDOW_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_PROC} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [TO_W-1:0]    to_q, to_d;
    logic [14:0]        samp_q, samp_d;
    logic [14:0]        base_q, base_d;
    logic               base_valid_q, base_valid_d;
    logic [14:0]        peak_q, peak_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [14:0]        level_q, level_d;
    logic               level_stb_q, level_stb_d;
    logic               loud_q, loud_d;
    logic               rd_start_q, rd_start_d;
    logic               to_err_q, to_err_d;
    logic               ovr_err_q, ovr_err_d;

    logic               tick_c;
    logic signed [15:0] diff_c;
    logic [14:0]        amp_c;
    logic [14:0]        peak_new_c;
    logic [14:0]        base_upd_c;
    logic               unused_rd_bit15;

    assign unused_rd_bit15 = bus.rdData[15];

    // Sample-period counter; held at zero while sampling is disabled.
    assign tick_c = bus.enable && (cnt_q == CNT_W'(PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!bus.enable || tick_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Amplitude against the old baseline; baseline follows by diff>>>BASE_SHIFT.
    assign diff_c     = $signed({1'b0, samp_q}) - $signed({1'b0, base_q});
    assign amp_c      = !base_valid_q ? 15'd0 :
                        (diff_c[15] ? 15'(-diff_c) : diff_c[14:0]);
    assign peak_new_c = (amp_c > peak_q) ? amp_c : peak_q;
    assign base_upd_c = 15'($signed({1'b0, base_q}) + (diff_c >>> BASE_SHIFT));

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        to_d         = to_q;
        samp_d       = samp_q;
        base_d       = base_q;
        base_valid_d = base_valid_q;
        peak_d       = peak_q;
        win_d        = win_q;
        level_d      = level_q;
        level_stb_d  = 1'b0;
        loud_d       = loud_q;
        rd_start_d   = 1'b0;
        to_err_d     = to_err_q;
        ovr_err_d    = ovr_err_q;

        // A tick mid-conversion is dropped, only flagged.
        if (tick_c && (state_q != S_IDLE)) begin
            ovr_err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (tick_c) begin
                    state_d    = S_START;
                    rd_start_d = 1'b1;
                end
            end
            S_START: begin
                to_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.rdStrobe) begin
                    samp_d  = bus.rdData[14:0];
                    state_d = S_PROC;
                end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                    to_err_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_PROC: begin
                state_d = S_IDLE;
                if (!base_valid_q) begin
                    base_d       = samp_q;
                    base_valid_d = 1'b1;
                end else begin
                    base_d = base_upd_c;
                end
                peak_d = peak_new_c;
                win_d  = win_q + WIN_W'(1);
                // Last sample of the window: publish and restart the peak hold.
                if (win_q == '1) begin
                    level_d     = peak_new_c;
                    level_stb_d = 1'b1;
                    peak_d      = '0;
                    if (peak_new_c >= THRESH_ON) begin
                        loud_d = 1'b1;
                    end else if (peak_new_c < THRESH_OFF) begin
                        loud_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            to_q         <= '0;
            samp_q       <= '0;
            base_q       <= '0;
            base_valid_q <= 1'b0;
            peak_q       <= '0;
            win_q        <= '0;
            level_q      <= '0;
            level_stb_q  <= 1'b0;
            loud_q       <= 1'b0;
            rd_start_q   <= 1'b0;
            to_err_q     <= 1'b0;
            ovr_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            to_q         <= to_d;
            samp_q       <= samp_d;
            base_q       <= base_d;
            base_valid_q <= base_valid_d;
            peak_q       <= peak_d;
            win_q        <= win_d;
            level_q      <= level_d;
            level_stb_q  <= level_stb_d;
            loud_q       <= loud_d;
            rd_start_q   <= rd_start_d;
            to_err_q     <= to_err_d;
            ovr_err_q    <= ovr_err_d;
        end
    end

    assign bus.rdStart     = rd_start_q;
    assign bus.level       = level_q;
    assign bus.levelStrobe = level_stb_q;
    assign bus.loud        = loud_q;
    assign bus.timeoutErr  = to_err_q;
    assign bus.overrunErr  = ovr_err_q;
endmodule
